// File: rtl/screen_sequencer.sv
// Screen sequencer: switches START/GAME/RESULT screens with a frame-paced
// fade-out / fade-in, and composites the selected renderer's pixel colour.
module screen_sequencer #(
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        vs,
  input  logic        active_nblank,
  input  logic        start_req,
  input  logic        end_req,
  input  logic [11:0] start_rgb,
  input  logic [11:0] game_rgb,
  input  logic [11:0] result_rgb,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic [1:0]  screen_sel,
  output logic        busy,
  output logic        req_ack
);

  typedef enum logic [1:0] {STABLE, PENDING, FADE_OUT, FADE_IN} phase_t;
  typedef enum logic [1:0] {SCR_START, SCR_GAME, SCR_RESULT} screen_t;

  localparam logic [3:0] CNT_LAST = 4'(FRAMES_PER_STEP - 1);

  phase_t      phase, phase_nx;
  screen_t     screen, screen_nx, target, target_nx;
  logic [4:0]  level, level_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        ack_nx;
  logic        vs_q;
  logic        fb;
  logic [11:0] src;

  // vs_q resets low so a vs held low across reset release is not seen as an edge.
  assign fb = vs_q & ~vs;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= STABLE;
      screen  <= SCR_START;
      target  <= SCR_START;
      level   <= 5'd16;
      cnt     <= '0;
      req_ack <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      phase   <= phase_nx;
      screen  <= screen_nx;
      target  <= target_nx;
      level   <= level_nx;
      cnt     <= cnt_nx;
      req_ack <= ack_nx;
      vs_q    <= vs;
    end
  end

  always_comb begin
    phase_nx  = phase;
    screen_nx = screen;
    target_nx = target;
    level_nx  = level;
    cnt_nx    = cnt;
    ack_nx    = 1'b0;
    unique case (phase)
      STABLE: begin
        // At most one request is meaningful per screen; the other is dropped.
        if (screen == SCR_START && start_req) begin
          target_nx = SCR_GAME;
          ack_nx    = 1'b1;
          phase_nx  = PENDING;
        end else if (screen == SCR_GAME && end_req) begin
          target_nx = SCR_RESULT;
          ack_nx    = 1'b1;
          phase_nx  = PENDING;
        end else if (screen == SCR_RESULT && start_req) begin
          target_nx = SCR_START;
          ack_nx    = 1'b1;
          phase_nx  = PENDING;
        end
      end
      PENDING: begin
        if (fb) phase_nx = FADE_OUT;
      end
      FADE_OUT: begin
        if (fb) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            level_nx = level - 5'd1;
            if (level == 5'd1) begin
              screen_nx = target;
              phase_nx  = FADE_IN;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      FADE_IN: begin
        if (fb) begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            level_nx = level + 5'd1;
            if (level == 5'd15) phase_nx = STABLE;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
      end
      default: phase_nx = STABLE;
    endcase
  end

  assign busy       = (phase != STABLE);
  assign screen_sel = screen;

  always_comb begin
    unique case (screen)
      SCR_GAME:   src = game_rgb;
      SCR_RESULT: src = result_rgb;
      default:    src = start_rgb;
    endcase
  end

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] l);
    logic [8:0] p;
    p = 9'(c) * 9'(l);
    return p[7:4];
  endfunction

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end else if (active_nblank) begin
      Red   <= scale(src[11:8], level);
      Green <= scale(src[7:4], level);
      Blue  <= scale(src[3:0], level);
    end else begin
      Red   <= '0;
      Green <= '0;
      Blue  <= '0;
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: pixel-path vectors, fade timing, request
// filtering, reset abort and a full screen cycle.
module tb_screen_sequencer;

  localparam int unsigned FPS = 2;

  logic        pixel_clk = 1'b0;
  logic        reset_n, vs, active_nblank, start_req, end_req;
  logic [11:0] start_rgb, game_rgb, result_rgb;
  logic [3:0]  Red, Green, Blue;
  logic [1:0]  screen_sel;
  logic        busy, req_ack;

  int compared   = 0;
  int mismatched = 0;
  int ack_cnt    = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic        act;
    logic [11:0] rgb;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[6];

  screen_sequencer #(.FRAMES_PER_STEP(FPS)) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .vs(vs),
    .active_nblank(active_nblank), .start_req(start_req), .end_req(end_req),
    .start_rgb(start_rgb), .game_rgb(game_rgb), .result_rgb(result_rgb),
    .Red(Red), .Green(Green), .Blue(Blue),
    .screen_sel(screen_sel), .busy(busy), .req_ack(req_ack)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(negedge pixel_clk) if (reset_n === 1'b1 && req_ack === 1'b1) ack_cnt++;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_rgb(input string name);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no expected value queued", name);
    end else begin
      e = exp_q.pop_front();
      check(name, {Red, Green, Blue}, e);
    end
  endtask

  function automatic logic [11:0] faded(input int lvl);
    logic [3:0] c;
    c = 4'((15 * lvl) >> 4);
    return {c, c, c};
  endfunction

  // One frame boundary: vs falls for one cycle, then two cycles high so the
  // composited output reflects the updated level.
  task automatic frame();
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
    tick();
  endtask

  task automatic request(input logic s, input logic e, input logic exp_ack, input string name);
    start_req = s;
    end_req   = e;
    tick();
    start_req = 1'b0;
    end_req   = 1'b0;
    check({name, " ack"}, {11'b0, req_ack}, {11'b0, exp_ack});
    check({name, " busy"}, {11'b0, busy}, {11'b0, exp_ack});
    tick();
    check({name, " ack pulse end"}, {11'b0, req_ack}, 12'h0);
  endtask

  // Assumes all renderers drive FFF with active video, request already accepted.
  task automatic run_fade(input logic [1:0] from, input logic [1:0] dest, input bit mid);
    frame();
    check("pending->fade_out busy", {11'b0, busy}, 12'h1);
    for (int n = 1; n <= 16 * FPS; n++) begin
      frame();
      exp_q.push_back(faded(16 - n / FPS));
      pop_rgb("fade_out level");
      check("fade_out screen_sel", {10'b0, screen_sel}, {10'b0, (n == 16 * FPS) ? dest : from});
      if (mid && n == 8 * FPS) begin
        end_req = 1'b1;
        tick();
        end_req = 1'b0;
        check("mid-fade end_req ack", {11'b0, req_ack}, 12'h0);
        tick();
        check("mid-fade end_req ack2", {11'b0, req_ack}, 12'h0);
      end
    end
    for (int m = 1; m <= 16 * FPS; m++) begin
      frame();
      exp_q.push_back(faded(m / FPS));
      pop_rgb("fade_in level");
      check("fade_in busy", {11'b0, busy}, {11'b0, (m < 16 * FPS)});
      check("fade_in screen_sel", {10'b0, screen_sel}, {10'b0, dest});
    end
  endtask

  int ack_base;

  initial begin
    reset_n       = 1'b0;
    vs            = 1'b1;
    active_nblank = 1'b0;
    start_req     = 1'b0;
    end_req       = 1'b0;
    start_rgb     = 12'h000;
    game_rgb      = 12'h111;
    result_rgb    = 12'h222;

    vecs[0] = '{1'b1, 12'hF84, 12'hF84};
    vecs[1] = '{1'b0, 12'hF84, 12'h000};
    vecs[2] = '{1'b1, 12'h123, 12'h123};
    vecs[3] = '{1'b1, 12'hFFF, 12'hFFF};
    vecs[4] = '{1'b0, 12'hFFF, 12'h000};
    vecs[5] = '{1'b1, 12'h0A5, 12'h0A5};

    #2;
    check("reset rgb", {Red, Green, Blue}, 12'h000);
    check("reset busy", {11'b0, busy}, 12'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post-reset screen_sel", {10'b0, screen_sel}, 12'h0);
    check("post-reset busy", {11'b0, busy}, 12'h0);
    check("post-reset ack", {11'b0, req_ack}, 12'h0);

    foreach (vecs[i]) begin
      active_nblank = vecs[i].act;
      start_rgb     = vecs[i].rgb;
      exp_q.push_back(vecs[i].exp);
      tick();
      pop_rgb("pixel vector");
    end

    request(1'b0, 1'b1, 1'b0, "START end_req ignored");
    check("START end_req busy", {11'b0, busy}, 12'h0);

    start_rgb     = 12'hFFF;
    game_rgb      = 12'hFFF;
    result_rgb    = 12'hFFF;
    active_nblank = 1'b1;
    ack_base      = ack_cnt;

    request(1'b1, 1'b0, 1'b1, "START->GAME");
    run_fade(2'd0, 2'd1, 1'b1);
    request(1'b1, 1'b1, 1'b1, "GAME both reqs");
    run_fade(2'd1, 2'd2, 1'b0);
    request(1'b0, 1'b1, 1'b0, "RESULT end_req ignored");
    request(1'b1, 1'b0, 1'b1, "RESULT->START");
    run_fade(2'd2, 2'd0, 1'b0);
    check("ack count full cycle", 12'(ack_cnt - ack_base), 12'd3);

    request(1'b1, 1'b0, 1'b1, "abort transition");
    frame();
    for (int n = 0; n < 16 * FPS; n++) frame();
    for (int m = 0; m < 5 * FPS; m++) frame();
    exp_q.push_back(faded(5));
    pop_rgb("fade_in level 5");
    check("fade_in level 5 screen", {10'b0, screen_sel}, 12'h1);
    vs = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("abort screen_sel", {10'b0, screen_sel}, 12'h0);
    check("abort busy", {11'b0, busy}, 12'h0);
    check("abort rgb", {Red, Green, Blue}, 12'h000);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    exp_q.push_back(12'hFFF);
    pop_rgb("release level 16");
    check("release busy", {11'b0, busy}, 12'h0);
    vs = 1'b1;
    tick();
    tick();
    check("release busy later", {11'b0, busy}, 12'h0);
    check("release screen_sel", {10'b0, screen_sel}, 12'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
